// File: rtl/lut_sched_pkg.sv
// Shared constants, state encoding and selection-entry layout for the LUT layer scheduler.
package lut_sched_pkg;
    localparam int N_FEAT = 16;
    localparam int N_NEUR = 32;
    localparam int BW     = 4;
    localparam int FANIN  = 3;
    localparam int ADDR_W = FANIN * BW;
    localparam int NIDX_W = 5;
    localparam int FIDX_W = 4;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    typedef struct packed {
        logic [FIDX_W-1:0] hi;
        logic [FIDX_W-1:0] mid;
        logic [FIDX_W-1:0] lo;
    } sel_entry_t;

    function automatic logic [BW-1:0] pick_feat(input logic [N_FEAT*BW-1:0] vec,
                                                input logic [FIDX_W-1:0]    idx);
        return vec[idx*BW +: BW];
    endfunction
endpackage

// File: rtl/lut_fanin_table.sv
// Per-neuron fan-in selection register file plus the 3-way feature muxes that form addr12.
// Writes land at the clock edge; addr12 is combinational from rd_idx and the feature vector.
module lut_fanin_table
    import lut_sched_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [NIDX_W-1:0]      wr_idx,
    input  logic [ADDR_W-1:0]      wr_sel,
    input  logic [NIDX_W-1:0]      rd_idx,
    input  logic [N_FEAT*BW-1:0]   feat_vec,
    output logic [ADDR_W-1:0]      addr12
);
    sel_entry_t tbl [N_NEUR];
    sel_entry_t ent;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_NEUR; i++) begin
                tbl[i] <= '0;
            end
        end else if (we) begin
            tbl[wr_idx] <= sel_entry_t'(wr_sel);
        end
    end

    assign ent    = tbl[rd_idx];
    assign addr12 = {pick_feat(feat_vec, ent.hi),
                     pick_feat(feat_vec, ent.mid),
                     pick_feat(feat_vec, ent.lo)};
endmodule

// File: rtl/lut_layer_scheduler.sv
// One LUT layer evaluated one neuron per cycle against a shared truth table; result valid 34 cycles after accept, held until out_ready.
// Optional perf_done/perf_stall counters are built when LUT_SCHED_PERF_EN is defined.
module lut_layer_scheduler
    import lut_sched_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_FEAT*BW-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_NEUR*BW-1:0]   out_data,
    output logic                   lut_en,
    output logic [NIDX_W+ADDR_W-1:0] lut_addr,
    input  logic [BW-1:0]          lut_rdata,
    input  logic                   cfg_we,
    input  logic [NIDX_W-1:0]      cfg_neuron,
    input  logic [ADDR_W-1:0]      cfg_sel,
    output logic                   cfg_ready,
    output logic                   busy
`ifdef LUT_SCHED_PERF_EN
    ,
    output logic [31:0]            perf_done,
    output logic [31:0]            perf_stall
`endif
);
    state_t                 state;
    logic [NIDX_W-1:0]      n;
    logic [NIDX_W-1:0]      wb_idx;
    logic                   wb_vld;
    logic [N_FEAT*BW-1:0]   feat_q;
    logic [ADDR_W-1:0]      addr12;
    logic [N_NEUR*BW-1:0]   res_q;

    // Table writes are only taken in IDLE, so the table is frozen while a vector is in flight.
    lut_fanin_table u_table (
        .clk      (clk),
        .rst      (rst),
        .we       (cfg_we && cfg_ready),
        .wr_idx   (cfg_neuron),
        .wr_sel   (cfg_sel),
        .rd_idx   (n),
        .feat_vec (feat_q),
        .addr12   (addr12)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            n      <= '0;
            feat_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        feat_q <= in_data;
                        n      <= '0;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    n <= n + 1'b1;
                    if (n == NIDX_W'(N_NEUR - 1)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: state <= ST_DONE;
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read data returns one cycle after the strobe, so the writeback index trails n by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_vld <= 1'b0;
            wb_idx <= '0;
            res_q  <= '0;
        end else begin
            wb_vld <= (state == ST_ISSUE);
            wb_idx <= n;
            if (wb_vld) begin
                res_q[wb_idx*BW +: BW] <= lut_rdata;
            end
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign cfg_ready = (state == ST_IDLE);
    assign busy      = (state == ST_ISSUE) || (state == ST_DRAIN);
    assign out_valid = (state == ST_DONE);
    assign lut_en    = (state == ST_ISSUE);
    assign lut_addr  = lut_en ? {n, addr12} : '0;
    assign out_data  = res_q;

`ifdef LUT_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_done  <= '0;
            perf_stall <= '0;
        end else if (state == ST_DONE) begin
            if (out_ready) begin
                perf_done <= perf_done + 32'd1;
            end else begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif
endmodule
